// File: rtl/rom_load_ctrl.sv
// Cartridge ROM loader: packs iosys bytes into big-endian words, buffers them,
// writes them to SDRAM over a toggle req/ack port, and gates core run (md_on).
module rom_load_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 22
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [2:0]           loading,
  input  logic [7:0]           loader_do,
  input  logic                 loader_do_valid,
  output logic [ADDR_BITS-2:0] mem_addr,
  output logic [15:0]          mem_din,
  output logic [1:0]           mem_be,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 md_on,
  output logic [ADDR_BITS-1:0] rom_size,
  output logic                 busy,
  output logic                 overflow
);

  // state   | meaning
  // S_OFF   | after reset, core held, waiting for first load
  // S_LOAD  | accepting ROM bytes, core held
  // S_FLUSH | load ended, draining partial word, FIFO and outstanding write
  // S_RUN   | core released with final rom_size
  // S_ABORT | reload during flush: wait for the pending ack, then discard FIFO
  // W_IDLE  | no SDRAM write outstanding
  // W_WAIT  | write issued, waiting for mem_ack == mem_req

  typedef enum logic [2:0] {S_OFF, S_LOAD, S_FLUSH, S_RUN, S_ABORT} ctrl_t;
  typedef enum logic {W_IDLE, W_WAIT} wr_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_BITS + 17;

  ctrl_t state, state_nx;
  wr_t   wr_state, wr_nx;

  logic [2:0]           loading_q;
  logic [ADDR_BITS-1:0] byte_cnt;
  logic [7:0]           pack_hi;
  logic                 pack_valid;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full;

  logic          load_rise, req_done;
  logic          enter_load, finish, fifo_clr, byte_acc, partial;
  logic          push, push_ok, pop, ovf_set;
  logic [EW-1:0] push_entry, rd_entry;

  assign load_rise  = (loading != 3'd0) && (loading_q == 3'd0);
  assign req_done   = (mem_ack == mem_req);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign rd_entry   = fifo_mem[rd_ptr];

  always_comb begin
    state_nx   = state;
    enter_load = 1'b0;
    finish     = 1'b0;
    fifo_clr   = 1'b0;
    byte_acc   = 1'b0;
    partial    = 1'b0;
    case (state)
      S_OFF, S_RUN: begin
        if (load_rise) begin
          state_nx   = S_LOAD;
          enter_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (loading == 3'd0)
          state_nx = S_FLUSH;
        else if (loading == 3'd1 && loader_do_valid)
          byte_acc = 1'b1;
      end
      S_FLUSH: begin
        if (load_rise)
          state_nx = S_ABORT;
        else if (pack_valid)
          partial = 1'b1;
        else if (fifo_empty && wr_state == W_IDLE) begin
          state_nx = S_RUN;
          finish   = 1'b1;
        end
      end
      S_ABORT: begin
        if (req_done) begin
          state_nx   = S_LOAD;
          enter_load = 1'b1;
          fifo_clr   = 1'b1;
        end
      end
      default: state_nx = S_OFF;
    endcase
  end

  // The in-flight write is never cancelled; only queued words are discarded.
  always_comb begin
    wr_nx = wr_state;
    pop   = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (!fifo_empty && state != S_ABORT) begin
          pop   = 1'b1;
          wr_nx = W_WAIT;
        end
      end
      W_WAIT: if (req_done) wr_nx = W_IDLE;
      default: wr_nx = W_IDLE;
    endcase
  end

  assign push       = (byte_acc && pack_valid) || partial;
  assign push_ok    = push && (!fifo_full || pop);
  assign ovf_set    = push && !push_ok;
  assign push_entry = {byte_cnt[ADDR_BITS-1:1], pack_hi,
                       byte_acc ? loader_do : 8'h00,
                       byte_acc ? 2'b11 : 2'b10};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_OFF;
      wr_state   <= W_IDLE;
      loading_q  <= 3'd0;
      byte_cnt   <= '0;
      pack_hi    <= 8'h00;
      pack_valid <= 1'b0;
      md_on      <= 1'b0;
      rom_size   <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 16'h0000;
      mem_be     <= 2'b00;
      mem_req    <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_state  <= wr_nx;
      loading_q <= loading;
      if (enter_load) begin
        md_on      <= 1'b0;
        byte_cnt   <= '0;
        pack_hi    <= 8'h00;
        pack_valid <= 1'b0;
        overflow   <= 1'b0;
        busy       <= 1'b1;
      end else begin
        if (byte_acc) begin
          byte_cnt <= byte_cnt + ADDR_BITS'(1);
          if (!pack_valid) begin
            pack_hi    <= loader_do;
            pack_valid <= 1'b1;
          end else begin
            pack_valid <= 1'b0;
          end
        end
        if (partial) pack_valid <= 1'b0;
        if (ovf_set) overflow <= 1'b1;
      end
      if (finish) begin
        rom_size <= byte_cnt;
        md_on    <= 1'b1;
        busy     <= 1'b0;
      end
      if (pop) begin
        mem_addr <= rd_entry[EW-1:18];
        mem_din  <= rd_entry[17:2];
        mem_be   <= rd_entry[1:0];
        mem_req  <= ~mem_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || fifo_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl with a delayed toggle-ack SDRAM model and a write log.
module tb_rom_load_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  loading = 3'd0;
  logic [7:0]  loader_do = 8'h00;
  logic        loader_do_valid = 1'b0;
  logic [20:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic        md_on;
  logic [21:0] rom_size;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  int viol = 0;

  logic [20:0] wa[$];
  logic [15:0] wd[$];
  logic [1:0]  wb[$];
  logic        m_req = 1'b0;
  logic        m_pend = 1'b0;

  rom_load_ctrl dut (
    .clk(clk), .resetn(resetn), .loading(loading), .loader_do(loader_do),
    .loader_do_valid(loader_do_valid), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_be(mem_be), .mem_req(mem_req), .mem_ack(mem_ack), .md_on(md_on),
    .rom_size(rom_size), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // SDRAM model: acks after ack_delay cycles of pending request, reset with the DUT
  always @(posedge clk) begin
    logic rs;
    rs = resetn;
    #2;
    if (!rs) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_req !== mem_ack) begin
      ack_cnt++;
      if (ack_cnt > ack_delay) begin
        mem_ack = mem_req;
        ack_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req !== m_req) begin
      if (m_pend) viol++;
      wa.push_back(mem_addr);
      wd.push_back(mem_din);
      wb.push_back(mem_be);
    end
    m_pend = (mem_req !== mem_ack);
    m_req  = mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wb.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    loader_do = b;
    loader_do_valid = 1'b1;
    tick();
    loader_do_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic wait_md(input int limit);
    for (int i = 0; i < limit && md_on !== 1'b1; i++) tick();
    checks++;
    if (md_on !== 1'b1) begin
      errors++;
      $display("FAIL md_on_timeout: md_on=%b required 1", md_on);
    end
  endtask

  task automatic check_write(input int idx, input logic [20:0] a, input logic [15:0] d,
                             input logic [1:0] be);
    checks++;
    if (wa.size() <= idx) begin
      errors++;
      $display("FAIL write%0d_missing: log size %0d", idx, wa.size());
    end else if (wa[idx] !== a || wd[idx] !== d || wb[idx] !== be) begin
      errors++;
      $display("FAIL write%0d: got addr %h din %h be %b required addr %h din %h be %b",
               idx, wa[idx], wd[idx], wb[idx], a, d, be);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    checks++;
    if ({md_on, mem_req, mem_addr, mem_din, mem_be, rom_size, busy, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_values: md_on %b req %b addr %h din %h be %b size %0d busy %b ovf %b required all 0",
               md_on, mem_req, mem_addr, mem_din, mem_be, rom_size, busy, overflow);
    end
  endtask

  task automatic test_basic();
    clear_log();
    ack_delay = 0;
    loading = 3'd1;
    tick();
    checks++;
    if (busy !== 1'b1 || md_on !== 1'b0) begin
      errors++;
      $display("FAIL basic_load_entry: busy %b md_on %b required 1 0", busy, md_on);
    end
    send_byte(8'h12, 4);
    loader_do = 8'h34;
    loader_do_valid = 1'b1;
    tick();
    loader_do_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: mem_req %b required 0", mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 21'd0 || mem_din !== 16'h1234 || mem_be !== 2'b11) begin
      errors++;
      $display("FAIL latency_issue: req %b addr %h din %h be %b required 1 0 1234 11",
               mem_req, mem_addr, mem_din, mem_be);
    end
    repeat (2) tick();
    send_byte(8'h56, 4);
    send_byte(8'h78, 4);
    loading = 3'd0;
    wait_md(100);
    check_write(0, 21'd0, 16'h1234, 2'b11);
    check_write(1, 21'd1, 16'h5678, 2'b11);
    checks++;
    if (rom_size !== 22'd4 || busy !== 1'b0 || wa.size() != 2) begin
      errors++;
      $display("FAIL basic_done: size %0d busy %b writes %0d required 4 0 2",
               rom_size, busy, wa.size());
    end
  endtask

  task automatic test_odd_length();
    clear_log();
    ack_delay = 10;
    loading = 3'd1;
    tick();
    checks++;
    if (md_on !== 1'b0) begin
      errors++;
      $display("FAIL odd_md_on_drop: md_on %b required 0", md_on);
    end
    send_byte(8'hAA, 4);
    send_byte(8'hBB, 4);
    send_byte(8'hCC, 4);
    loading = 3'd0;
    for (int i = 0; i < 200 && wa.size() < 2; i++) tick();
    checks++;
    if (md_on !== 1'b0 || mem_req === mem_ack) begin
      errors++;
      $display("FAIL odd_md_before_ack: md_on %b pending %b required 0 1",
               md_on, mem_req !== mem_ack);
    end
    wait_md(200);
    check_write(0, 21'd0, 16'hAABB, 2'b11);
    check_write(1, 21'd1, 16'hCC00, 2'b10);
    checks++;
    if (rom_size !== 22'd3) begin
      errors++;
      $display("FAIL odd_rom_size: got %0d required 3", rom_size);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    viol = 0;
    ack_delay = 20;
    loading = 3'd1;
    tick();
    for (int i = 0; i < 12; i++) begin
      loader_do = 8'h10 + 8'(i);
      loader_do_valid = 1'b1;
      tick();
    end
    loader_do_valid = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got %b required 1", overflow);
    end
    loading = 3'd0;
    wait_md(400);
    checks++;
    if (wa.size() != 5) begin
      errors++;
      $display("FAIL bp_write_count: got %0d required 5", wa.size());
    end
    check_write(0, 21'd0, 16'h1011, 2'b11);
    check_write(4, 21'd4, 16'h1819, 2'b11);
    checks++;
    if (rom_size !== 22'd12 || overflow !== 1'b1 || viol != 0) begin
      errors++;
      $display("FAIL bp_done: size %0d ovf %b violations %0d required 12 1 0",
               rom_size, overflow, viol);
    end
  endtask

  task automatic test_cartram();
    clear_log();
    ack_delay = 0;
    loading = 3'd2;
    tick();
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cart_load_entry: ovf %b busy %b required 0 1", overflow, busy);
    end
    for (int i = 0; i < 8; i++) send_byte(8'hE0 + 8'(i), 2);
    repeat (3) tick();
    checks++;
    if (wa.size() != 0 || md_on !== 1'b0) begin
      errors++;
      $display("FAIL cart_ignored: writes %0d md_on %b required 0 0", wa.size(), md_on);
    end
    loading = 3'd0;
    wait_md(50);
    checks++;
    if (rom_size !== 22'd0) begin
      errors++;
      $display("FAIL cart_rom_size: got %0d required 0", rom_size);
    end
  endtask

  task automatic test_reload_abort();
    clear_log();
    ack_delay = 30;
    loading = 3'd1;
    tick();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 2);
    loading = 3'd0;
    repeat (2) tick();
    loading = 3'd1;
    tick();
    for (int i = 0; i < 80 && mem_req !== mem_ack; i++) tick();
    checks++;
    if (wa.size() != 1) begin
      errors++;
      $display("FAIL abort_no_toggle: writes %0d required 1", wa.size());
    end
    ack_delay = 0;
    repeat (6) tick();
    checks++;
    if (wa.size() != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_discard: writes %0d busy %b required 1 1", wa.size(), busy);
    end
    send_byte(8'h0A, 2);
    send_byte(8'h0B, 2);
    loading = 3'd0;
    wait_md(100);
    check_write(0, 21'd0, 16'h0102, 2'b11);
    check_write(1, 21'd0, 16'h0A0B, 2'b11);
    checks++;
    if (rom_size !== 22'd2 || wa.size() != 2) begin
      errors++;
      $display("FAIL abort_done: size %0d writes %0d required 2 2", rom_size, wa.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_log();
    ack_delay = 5;
    loading = 3'd1;
    tick();
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 2);
    for (int i = 0; i < 100 && wa.size() < 2; i++) tick();
    checks++;
    if (mem_req !== 1'b1 || mem_ack !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_pending: req %b ack %b required 1 0", mem_req, mem_ack);
    end
    loading = 3'd0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++;
    if ({md_on, mem_req, mem_addr, mem_din, mem_be, rom_size, busy, overflow} !== '0) begin
      errors++;
      $display("FAIL midwait_reset: md_on %b req %b addr %h din %h be %b size %0d busy %b ovf %b required all 0",
               md_on, mem_req, mem_addr, mem_din, mem_be, rom_size, busy, overflow);
    end
    ack_delay = 0;
    tick();
    clear_log();
    loading = 3'd1;
    tick();
    send_byte(8'h5A, 2);
    send_byte(8'hA5, 2);
    loading = 3'd0;
    wait_md(100);
    check_write(0, 21'd0, 16'h5AA5, 2'b11);
    checks++;
    if (rom_size !== 22'd2 || wa.size() != 1) begin
      errors++;
      $display("FAIL post_reset_load: size %0d writes %0d required 2 1", rom_size, wa.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_backpressure();
    test_cartram();
    test_reload_abort();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
